// File: rtl/sass_audio_pkg.sv
// rtl/sass_audio_pkg.sv - shared widths, types and sample-to-duty helper for the PWM audio path
package sass_audio_pkg;

    localparam int SAMPLE_W = 9;
    localparam int CNT_W    = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [CNT_W-1:0]    duty_t;

    // Keep the top CNT_W bits of the sample; the low bits are dropped without rounding.
    function automatic duty_t sample_to_duty(input sample_t s);
        return duty_t'(s >> (SAMPLE_W - CNT_W));
    endfunction

endpackage

// File: rtl/pwm_counter.sv
// rtl/pwm_counter.sv - free-running period counter with registered duty compare
//
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   enable     : count this cycle; low clears cnt and forces pwm_o low next cycle
//   duty       : number of high cycles per 2**CNT_W-cycle period
//   cnt        : current position in the period
//   wrap       : high in the last counted cycle of a period
//   pwm_o      : registered (cnt < duty), one cycle behind cnt
module pwm_counter
    import sass_audio_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             pwm_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt   <= '0;
            pwm_o <= 1'b0;
        end else if (enable) begin
            cnt   <= cnt + CNT_W'(1);
            pwm_o <= (cnt < duty);
        end else begin
            cnt   <= '0;
            pwm_o <= 1'b0;
        end
    end

    assign wrap = enable && (cnt == CNT_MAX);

endmodule

// File: rtl/pwm_sampler.sv
// rtl/pwm_sampler.sv - requests one sample per PWM period, double-buffers it and applies it as duty
//
// Ports:
//   clk, n_rst : 12 MHz clock, asynchronous active-low reset
//   enable     : run the PWM and issue requests; low forces idle and clears buffered state
//   sample     : sample from soundpath, valid with done
//   done       : one-cycle strobe, sample valid
//   sample_now : one-cycle request at the start of each period
//   pwm_o      : registered PWM output to the external low-pass filter
//   underrun   : one-cycle pulse at a period boundary that found no fresh sample
module pwm_sampler
    import sass_audio_pkg::*;
(
    input  logic    clk,
    input  logic    n_rst,
    input  logic    enable,
    input  sample_t sample,
    input  logic    done,
    output logic    sample_now,
    output logic    pwm_o,
    output logic    underrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic             run;
    logic             capture;
    logic             req_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty;
    logic             wrap;
    sample_t          shadow;
    logic             shadow_valid;
    logic             pending;
    logic             primed;

    pwm_counter u_counter (
        .clk    (clk),
        .n_rst  (n_rst),
        .enable (run),
        .duty   (duty),
        .cnt    (cnt),
        .wrap   (wrap),
        .pwm_o  (pwm_o)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // The counter only advances while staying in RUN, so the first RUN cycle sees cnt=0.
        run      = (state == RUN) && (state_next == RUN);
        capture  = done && pending;
        // Registered request: high whenever the next cycle is a RUN cycle with cnt=0.
        req_next = (state_next == RUN) && (!run || (cnt == CNT_MAX));
    end

    // A boundary without a fresh sample is only an underrun once a sample has ever been applied.
    assign underrun = wrap && primed && !shadow_valid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            sample_now   <= 1'b0;
            pending      <= 1'b0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            primed       <= 1'b0;
            duty         <= '0;
        end else begin
            state      <= state_next;
            sample_now <= req_next;
            if (state_next == IDLE) begin
                pending      <= 1'b0;
                shadow_valid <= 1'b0;
                primed       <= 1'b0;
                duty         <= '0;
            end else begin
                if (capture) begin
                    shadow <= sample;
                end
                // A new request wins over a coincident capture so it stays outstanding.
                if (sample_now) begin
                    pending <= 1'b1;
                end else if (capture) begin
                    pending <= 1'b0;
                end
                if (wrap && shadow_valid) begin
                    duty   <= sample_to_duty(shadow);
                    primed <= 1'b1;
                end
                // A capture in the boundary cycle itself survives to the next boundary.
                if (capture) begin
                    shadow_valid <= 1'b1;
                end else if (wrap) begin
                    shadow_valid <= 1'b0;
                end
            end
        end
    end

endmodule
